strobe_sample_buffer: RTL and testbench
=======================================

Name: strobe_sample_buffer

Overview:
- Sits directly downstream of the strobe generator in the RX path.
- On every cycle where strobe is high, captures one I/Q sample pair and packs it into a 32-bit word {i_in, q_in}.
- Buffers the words in an internal circular FIFO and presents them to the packetiser through a valid/ready handshake.
- Detects overrun, halts capture, and reports it through a sticky flag until software clears it.

Parameters:
- ADDR_W, 4, log2 of FIFO depth (DEPTH = 2**ADDR_W = 16 words).
- HALT_ON_OVERRUN, 1, 1 = stop capture after overrun until clear; 0 = drop the sample and keep running.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable. Low flushes the FIFO and forces IDLE.
- strobe  in  1  one-cycle sample qualifier from the strobe generator.
- i_in  in  16  I sample, valid when strobe=1.
- q_in  in  16  Q sample, valid when strobe=1.
- out_data  out  32  {I[15:0], Q[15:0]} at the FIFO head.
- out_valid  out  1  head word is valid.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- clear_overrun  in  1  one-cycle pulse that clears the overrun flag and leaves HALT.
- overrun  out  1  sticky overrun indicator.
- level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; write/read pointers=0; level=0; out_valid=0; overrun=0; out_data=0. Release is synchronous to clock.
- Pointers are ADDR_W+1 bits; the MSB is the wrap bit.
  - empty = (wptr==rptr).
  - full = (wptr[ADDR_W] != rptr[ADDR_W]) && (low bits equal).
  - Pointers wrap modulo 2**(ADDR_W+1).
- Write: wr = strobe & (state==RUN) & ~full. The write stores {i_in,q_in} at wptr and increments wptr.
- Read: rd = out_valid & out_ready. The read increments rptr.
  - out_data is a registered read of mem[rptr_next], so out_data/out_valid are stable while out_valid=1 and out_ready=0.
- Latency: a sample written in cycle N appears with out_valid=1 in cycle N+1 when the FIFO was empty. Write-to-read (fall-through) latency is exactly 1 clock.
- level updates each cycle: +1 on wr only, -1 on rd only, unchanged on both or neither.
- Simultaneous rd & strobe while full: the read frees a slot, but the write is evaluated against the pre-read full flag. The sample is treated as an overrun; there is no write-through when full.
- State machine: IDLE, RUN, HALT.
  - IDLE: pointers are held equal (flushed); out_valid=0. If enable=1, go to RUN on the next clock.
  - RUN: normal capture.
    - strobe & full: set overrun=1 and drop the sample.
    - If HALT_ON_OVERRUN=1, the same event also moves the state to HALT.
  - HALT: no writes. Reads continue so the consumer can drain the FIFO. clear_overrun moves the state back to RUN.
  - From any state, enable=0 moves the state to IDLE on the next clock. This flushes the FIFO (rptr<=wptr) and discards any unread data; out_valid drops in the same cycle as the flush.
  - overrun is not cleared by enable=0. Only reset or clear_overrun clears it.
- clear_overrun arriving in the same cycle as a new overrun event: the set wins, and overrun stays 1.
- strobe is ignored in IDLE and HALT. A strobe held high for multiple cycles writes once per cycle; this is legal.
- Asynchronous reset mid-transfer: all state is discarded immediately, with no partial outputs.

Decomposition:
- Shared package holds:
  - state encodings: IDLE=2'b00, RUN=2'b01, HALT=2'b10 (default arm → IDLE);
  - sample-pair width constant (32);
  - the I-high/Q-low packing order.
- One natural sub-module is sample_fifo_mem: a 2-port RAM of DEPTH × 32 with a registered read port. Pointer, flag and control logic stays in the top.

Test Plan:
1. Reset then enable=1; strobe for 3 cycles with (I,Q) = (0x0001,0x8001), (0x0002,0x8002), (0x0003,0x8003); out_ready=1 → out_data sequence 0x00018001, 0x00028002, 0x00038003. First out_valid appears 1 clock after the first strobe; level returns to 0.
2. out_ready=0, 16 strobes → level=16 and no overrun. 17th strobe → overrun=1, state=HALT, and the 17th sample is absent from the drained data. Then set out_ready=1: exactly 16 words are read in order, after which out_valid=0.
3. In HALT, pulse clear_overrun → overrun=0 and state=RUN. The next strobe with (0xAAAA,0x5555) is read back as 0xAAAA5555.
4. FIFO full with strobe and out_ready high in the same cycle → the head word is read, the strobe sample is dropped, overrun=1, and level=15.
5. Load 5 words, drop enable for 1 cycle, then raise it → out_valid=0 and level=0 after the flush, while overrun keeps its prior value.
6. Assert reset=0 asynchronously mid-stream, between clock edges → out_valid, level and overrun go to 0 immediately. Capture resumes normally after release with enable=1.

Source files
------------

// File: rtl/strobe_sample_buffer_pkg.sv
// Shared definitions for the strobe sample buffer.
//   - capture state encodings (IDLE / RUN / HALT)
//   - sample widths and the I-high / Q-low packing of one sample pair
package strobe_sample_buffer_pkg;

  localparam int IQ_W     = 16;
  localparam int SAMPLE_W = 2 * IQ_W;   // one packed I/Q pair = 32 bits

  // Capture state encodings; kept as plain constants so legacy code that
  // compares against raw 2-bit codes keeps working.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  // Packing order: I occupies the upper half, Q the lower half.
  typedef struct packed {
    logic [IQ_W-1:0] i;
    logic [IQ_W-1:0] q;
  } iq_pair_t;

  function automatic logic [SAMPLE_W-1:0] pack_iq(input logic [IQ_W-1:0] i_s,
                                                  input logic [IQ_W-1:0] q_s);
    iq_pair_t p;
    p.i = i_s;
    p.q = q_s;
    return p;
  endfunction

endpackage

// File: rtl/strobe_sample_buffer_if.sv
// Sample-in / word-out bus of the strobe sample buffer.
//   strobe, i_in, q_in : sample pair from the strobe generator
//   out_data, out_valid: FIFO head word towards the packetiser
//   out_ready          : packetiser accepts the head word
// slave  = the buffer itself, master = the surrounding RX path / testbench.
interface strobe_sample_buffer_if;
  import strobe_sample_buffer_pkg::*;

  logic                strobe;
  logic [IQ_W-1:0]     i_in;
  logic [IQ_W-1:0]     q_in;
  logic [SAMPLE_W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output strobe, i_in, q_in, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  strobe, i_in, q_in, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/strobe_sample_buffer_mem.sv
// sample_fifo_mem: DEPTH x WIDTH two-port RAM, one write port and one
// registered read port.
//   clock, reset : clock and asynchronous active-low reset (read register only)
//   wr_en/addr/data : write port
//   rd_addr, rd_data: read address and registered read data
// A read of the address being written in the same cycle returns the new
// data, which gives the FIFO its one-clock fall-through.
module sample_fifo_mem #(
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/strobe_sample_buffer.sv
// strobe_sample_buffer: captures one I/Q pair per strobe into a circular
// FIFO and hands the packed words {I,Q} to the packetiser over valid/ready.
//   clock, reset    : clock, asynchronous active-low reset
//   enable          : capture enable; low flushes the FIFO and forces IDLE
//   clear_overrun   : pulse, clears the sticky overrun flag and leaves HALT
//   overrun         : sticky overrun indicator
//   level           : FIFO occupancy 0..DEPTH
//   bus             : strobe/i_in/q_in in, out_data/out_valid/out_ready out
module strobe_sample_buffer
  import strobe_sample_buffer_pkg::*;
#(
  parameter int ADDR_W          = 4,
  parameter bit HALT_ON_OVERRUN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_overrun,
  output logic              overrun,
  output logic [ADDR_W:0]   level,
  strobe_sample_buffer_if.slave bus
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0] wptr_reg, wptr_next;
  logic [ADDR_W:0] rptr_reg, rptr_next;
  logic [1:0]      state_reg, state_next;
  logic            overrun_reg, overrun_next;

  logic empty, full, in_run, wr, rd, ovr_event;

  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[ADDR_W] != rptr_reg[ADDR_W]) &&
                 (wptr_reg[ADDR_W-1:0] == rptr_reg[ADDR_W-1:0]);

  assign in_run    = (state_reg == ST_RUN);
  // Full is judged before any same-cycle read: a strobe into a full FIFO is
  // always an overrun, even if the consumer frees a slot in that cycle.
  assign ovr_event = in_run && bus.strobe && full;
  // A flush cycle (enable low) takes nothing in, so the FIFO ends up empty.
  assign wr        = in_run && bus.strobe && !full && enable;
  assign rd        = bus.out_valid && bus.out_ready;

  always_comb begin
    wptr_next = wptr_reg + {{ADDR_W{1'b0}}, wr};
    rptr_next = rptr_reg + {{ADDR_W{1'b0}}, rd};
    if (!enable) begin
      rptr_next = wptr_reg;   // flush: discard all unread words
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_RUN;
        ST_RUN:  if (ovr_event && HALT_ON_OVERRUN) state_next = ST_HALT;
        ST_HALT: if (clear_overrun) state_next = ST_RUN;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Set has priority over clear when both land in the same cycle.
  always_comb begin
    overrun_next = overrun_reg;
    if (ovr_event) begin
      overrun_next = 1'b1;
    end else if (clear_overrun) begin
      overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      state_reg   <= ST_IDLE;
      overrun_reg <= 1'b0;
    end else begin
      wptr_reg    <= wptr_next;
      rptr_reg    <= rptr_next;
      state_reg   <= state_next;
      overrun_reg <= overrun_next;
    end
  end

  // Read address is the next head, so the registered read already holds the
  // new head word when the pointers update.
  sample_fifo_mem #(
    .ADDR_W (ADDR_W),
    .WIDTH  (SAMPLE_W)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr),
    .wr_addr (wptr_reg[ADDR_W-1:0]),
    .wr_data (pack_iq(bus.i_in, bus.q_in)),
    .rd_addr (rptr_next[ADDR_W-1:0]),
    .rd_data (bus.out_data)
  );

  assign bus.out_valid = !empty;
  assign level         = wptr_reg - rptr_reg;
  assign overrun       = overrun_reg;

endmodule

// File: tb/tb_strobe_sample_buffer.sv
module tb_strobe_sample_buffer;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear_overrun;
  logic       overrun;
  logic [4:0] level;

  strobe_sample_buffer_if bus ();

  strobe_sample_buffer #(.ADDR_W(4), .HALT_ON_OVERRUN(1'b1)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .clear_overrun (clear_overrun),
    .overrun       (overrun),
    .level         (level),
    .bus           (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Words held in a queue; the mode is tracked as plain integers.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  logic [31:0] fifo_q[$];
  int          m_mode = M_IDLE;
  bit          m_ovr  = 0;
  bit          mdl_on = 0;

  task automatic model_step();
    int n;
    bit full_now, rd_now, ev, wr_now;
    n        = fifo_q.size();
    full_now = (n == 16);
    rd_now   = (n != 0) && bus.out_ready;
    ev       = (m_mode == M_RUN) && bus.strobe && full_now;
    wr_now   = (m_mode == M_RUN) && bus.strobe && !full_now && enable;
    if (!enable) fifo_q.delete();
    else begin
      if (rd_now) void'(fifo_q.pop_front());
      if (wr_now) fifo_q.push_back({bus.i_in, bus.q_in});
    end
    if (ev) m_ovr = 1;
    else if (clear_overrun) m_ovr = 0;
    if (!enable) m_mode = M_IDLE;
    else if (m_mode == M_IDLE) m_mode = M_RUN;
    else if (m_mode == M_RUN && ev) m_mode = M_HALT;
    else if (m_mode == M_HALT && clear_overrun) m_mode = M_RUN;
  endtask

  always @(negedge reset) begin
    fifo_q.delete();
    m_mode = M_IDLE;
    m_ovr  = 0;
  end

  // Single compare process: model advances on each edge, outputs checked 1ns later.
  always @(posedge clock) begin
    if (mdl_on && reset) model_step();
    #1;
    if (mdl_on && reset) begin
      chk("cmp_level", 32'(level), 32'(fifo_q.size()));
      chk("cmp_valid", 32'(bus.out_valid), 32'(fifo_q.size() != 0));
      chk("cmp_overrun", 32'(overrun), 32'(m_ovr));
      if (fifo_q.size() != 0) chk("cmp_data", bus.out_data, fifo_q[0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic put(input logic [15:0] i_s, input logic [15:0] q_s);
    bus.strobe = 1'b1;
    bus.i_in   = i_s;
    bus.q_in   = q_s;
    tick();
    bus.strobe = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; clear_overrun = 1'b0;
    bus.strobe = 1'b0; bus.i_in = '0; bus.q_in = '0; bus.out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_data", bus.out_data, 32'h0);
    reset = 1'b1;
    mdl_on = 1;

    // 1: fall-through and in-order streaming
    enable = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.strobe = 1'b1; bus.i_in = 16'h0001; bus.q_in = 16'h8001; tick();
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_w0", bus.out_data, 32'h00018001);
    bus.i_in = 16'h0002; bus.q_in = 16'h8002; tick();
    chk("t1_w1", bus.out_data, 32'h00028002);
    bus.i_in = 16'h0003; bus.q_in = 16'h8003; tick();
    chk("t1_w2", bus.out_data, 32'h00038003);
    bus.strobe = 1'b0; tick();
    chk("t1_level", 32'(level), 32'd0);
    chk("t1_empty", 32'(bus.out_valid), 32'd0);

    // 2: fill, overrun on the 17th, HALT ignores strobes, drain 16 in order
    bus.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) put(16'h0100 + 16'(k), 16'h0200 + 16'(k));
    chk("t2_full_level", 32'(level), 32'd16);
    chk("t2_no_ovr", 32'(overrun), 32'd0);
    put(16'hDEAD, 16'hBEEF);
    chk("t2_ovr", 32'(overrun), 32'd1);
    chk("t2_level16", 32'(level), 32'd16);
    put(16'hDEAD, 16'hBEEF);
    chk("t2_halt_level", 32'(level), 32'd16);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t2_drain_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_drain_data", bus.out_data, {16'h0100 + 16'(k), 16'h0200 + 16'(k)});
      tick();
    end
    chk("t2_drained", 32'(bus.out_valid), 32'd0);

    // 3: clear overrun, capture resumes
    clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
    chk("t3_clr", 32'(overrun), 32'd0);
    bus.out_ready = 1'b0;
    put(16'hAAAA, 16'h5555);
    chk("t3_data", bus.out_data, 32'hAAAA5555);
    chk("t3_level", 32'(level), 32'd1);
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0;

    // 4: strobe + read on a full FIFO
    for (int k = 0; k < 16; k++) put(16'h0300 + 16'(k), 16'h0400 + 16'(k));
    bus.out_ready = 1'b1;
    put(16'hDEAD, 16'hBEEF);
    bus.out_ready = 1'b0;
    chk("t4_level", 32'(level), 32'd15);
    chk("t4_ovr", 32'(overrun), 32'd1);
    chk("t4_head", bus.out_data, 32'h03010401);

    // 5: flush keeps overrun
    enable = 1'b0; tick();
    chk("t5_flush_level", 32'(level), 32'd0);
    chk("t5_flush_ovr", 32'(overrun), 32'd1);
    enable = 1'b1; tick();
    for (int k = 0; k < 5; k++) put(16'h0500 + 16'(k), 16'h0600);
    chk("t5_level5", 32'(level), 32'd5);
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_ovr", 32'(overrun), 32'd1);

    // 6: asynchronous reset between edges
    for (int k = 0; k < 3; k++) put(16'h0700 + 16'(k), 16'h0800);
    chk("t6_level3", 32'(level), 32'd3);
    #2; reset = 1'b0; #1;
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_ovr", 32'(overrun), 32'd0);
    chk("t6_data", bus.out_data, 32'h0);
    tick(); reset = 1'b1;
    tick();
    put(16'h1234, 16'h5678);
    chk("t6_resume", bus.out_data, 32'h12345678);
    bus.out_ready = 1'b1; tick();

    // random phase: model compared every cycle
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct = $urandom_range(10, 95);
      for (int c = 0; c < 200; c++) begin
        bus.strobe    = ($urandom_range(0, 99) < 60);
        bus.i_in      = 16'($urandom);
        bus.q_in      = 16'($urandom);
        bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
        enable        = ($urandom_range(0, 149) != 0);
        clear_overrun = ($urandom_range(0, 24) == 0);
        tick();
      end
    end
    bus.strobe = 1'b0; clear_overrun = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
